// File: rtl/count_capture_fifo.sv
// Captures strobed count samples tagged with a wrap flag into a FIFO drained over valid/ready.
// Optional CAPTURE_DROP_CNT_EN adds a saturating count of samples dropped while full.
module count_capture_fifo #(
  parameter int CNT_W = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CNT_W-1:0]         cnt_in,
  input  logic                     cnt_valid,
  output logic [CNT_W:0]           out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     full,
  output logic                     empty,
`ifdef CAPTURE_DROP_CNT_EN
  output logic [7:0]               drop_cnt,
`endif
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [CNT_W:0]   mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] last_cnt_q, last_cnt_d;
  logic             have_prev_q, have_prev_d;
  logic             push, pop, wrap;

  assign full      = (level_q == FULL_LVL);
  assign empty     = (level_q == '0);
  assign out_valid = ~empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign level     = level_q;

  // A sample offered while full is lost even if a pop frees a slot this cycle.
  assign push = cnt_valid & ~full;
  assign pop  = out_valid & out_ready;
  assign wrap = have_prev_q & (cnt_in < last_cnt_q);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    last_cnt_d  = last_cnt_q;
    have_prev_d = have_prev_q;
    if (push) begin
      wr_ptr_d    = wr_ptr_q + AW'(1);
      last_cnt_d  = cnt_in;
      have_prev_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      last_cnt_q  <= '0;
      have_prev_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      last_cnt_q  <= last_cnt_d;
      have_prev_q <= have_prev_d;
    end
  end

  // Storage needs no reset: entries are only visible once level counts them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {wrap, cnt_in};
    end
  end

`ifdef CAPTURE_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (cnt_valid && full && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed bench for count_capture_fifo (CNT_W=4, DEPTH=8); inputs driven and outputs sampled on falling edges.
module tb_count_capture_fifo;

  logic       clk;
  logic       rst;
  logic [3:0] cnt_in;
  logic       cnt_valid;
  logic [4:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       full;
  logic       empty;
  logic [3:0] level;
`ifdef CAPTURE_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  count_capture_fifo #(.CNT_W(4), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_in    (cnt_in),
    .cnt_valid (cnt_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .full      (full),
    .empty     (empty),
`ifdef CAPTURE_DROP_CNT_EN
    .drop_cnt  (drop_cnt),
`endif
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push_blocked(input logic [3:0] v);
    cnt_in = v;
    cnt_valid = 1'b1;
    step();
    cnt_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [4:0] exp);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cnt_in = '0;
    cnt_valid = 1'b0;
    out_ready = 1'b0;

    // 1: reset state
    step();
    chk("rst_in_valid", 32'(out_valid), 32'd0);
    chk("rst_in_level", 32'(level), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
`ifdef CAPTURE_DROP_CNT_EN
    chk("rst_drop", 32'(drop_cnt), 32'd0);
`endif

    // 2: wrap tagging across 15 -> 0
    push_blocked(4'd14);
    chk("s2_first_latency", 32'(out_data), 32'h0E);
    push_blocked(4'd15);
    push_blocked(4'd0);
    push_blocked(4'd1);
    chk("s2_level", 32'(level), 32'd4);
    pop_expect("s2_pop0", 5'h0E);
    pop_expect("s2_pop1", 5'h0F);
    pop_expect("s2_pop2", 5'h10);
    pop_expect("s2_pop3", 5'h01);
    chk("s2_empty", 32'(empty), 32'd1);

    // 3: fill, drop while full, drain
    do_reset();
    for (int i = 0; i < 8; i++) push_blocked(4'(i));
    chk("s3_full", 32'(full), 32'd1);
    chk("s3_level", 32'(level), 32'd8);
    push_blocked(4'd5);
    chk("s3_level_after_drop", 32'(level), 32'd8);
`ifdef CAPTURE_DROP_CNT_EN
    chk("s3_drop", 32'(drop_cnt), 32'd1);
`endif
    for (int i = 0; i < 8; i++) pop_expect($sformatf("s3_drain%0d", i), 5'(i));
    chk("s3_empty", 32'(empty), 32'd1);
    chk("s3_full_clr", 32'(full), 32'd0);

    // 4: simultaneous push and pop at level 3
    do_reset();
    push_blocked(4'd1);
    push_blocked(4'd2);
    push_blocked(4'd3);
    chk("s4_level3", 32'(level), 32'd3);
    chk("s4_head", 32'(out_data), 32'h01);
    cnt_in = 4'd4;
    cnt_valid = 1'b1;
    out_ready = 1'b1;
    step();
    cnt_valid = 1'b0;
    out_ready = 1'b0;
    chk("s4_level_same", 32'(level), 32'd3);
    pop_expect("s4_pop0", 5'h02);
    pop_expect("s4_pop1", 5'h03);
    pop_expect("s4_tail", 5'h04);
    chk("s4_empty", 32'(empty), 32'd1);

    // 5: async reset mid-operation
    do_reset();
    for (int i = 1; i <= 5; i++) push_blocked(4'(i));
    chk("s5_level5", 32'(level), 32'd5);
    rst = 1'b1;
    #1;
    chk("s5_async_level", 32'(level), 32'd0);
    chk("s5_async_valid", 32'(out_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    push_blocked(4'd2);
    chk("s5_level1", 32'(level), 32'd1);
    pop_expect("s5_after_rst", 5'h02);

    // 6: streaming with out_ready held high, counter wrapping
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cnt_in = 4'(i % 16);
      cnt_valid = 1'b1;
      step();
      chk($sformatf("s6_valid%0d", i), 32'(out_valid), 32'd1);
      chk($sformatf("s6_level%0d", i), 32'(level), 32'd1);
      chk($sformatf("s6_data%0d", i), 32'(out_data),
          {27'd0, ((i > 0) && (i % 16 == 0)), 4'(i % 16)});
    end
    cnt_valid = 1'b0;
    step();
    chk("s6_empty", 32'(empty), 32'd1);
    out_ready = 1'b0;

    // out_ready while empty is harmless
    out_ready = 1'b1;
    step();
    chk("idle_ready_level", 32'(level), 32'd0);
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
